// File: rtl/exc_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module  : exc_pkg                                                |
// | Purpose : FSM state type and EStatus cause codes for the         |
// |           exception request unit.                                |
// | Rev     : 1.0  initial release                                   |
// +------------------------------------------------------------------+
package exc_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        SERVICE = 2'd2
    } exc_state_t;

    localparam logic [3:0] EXC_INVOP    = 4'h1;
    localparam logic [3:0] EXC_TIMER    = 4'h4;
    localparam logic [3:0] EXC_IRQ_BASE = 4'h8;

endpackage
`default_nettype wire

// File: rtl/exc_request_ctrl_if.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module  : exc_request_ctrl_if                                    |
// | Purpose : Request/acknowledge handshake between the exception    |
// |           request unit (master) and the datapath (slave).        |
// | Rev     : 1.0  initial release                                   |
// +------------------------------------------------------------------+
interface exc_request_ctrl_if;

    logic       Exc;
    logic [3:0] EStatus;
    logic       ExcAck;

    modport master (output Exc, output EStatus, input ExcAck);
    modport slave  (input Exc, input EStatus, output ExcAck);

endinterface
`default_nettype wire

// File: rtl/irq_pending_bank.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module  : irq_pending_bank                                       |
// | Purpose : Rising-edge detect on IRQ lines with sticky pending    |
// |           bits; a new edge beats a same-cycle clear.             |
// | Rev     : 1.0  initial release                                   |
// +------------------------------------------------------------------+
module irq_pending_bank #(
    parameter int NIRQ = 4
) (
    input  wire logic            clk,
    input  wire logic            reset,
    input  wire logic [NIRQ-1:0] irq,
    input  wire logic [NIRQ-1:0] clr,
    output logic      [NIRQ-1:0] pending
);

    logic [NIRQ-1:0] irq_q;
    logic [NIRQ-1:0] edge_det;

    assign edge_det = irq & ~irq_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            irq_q   <= '0;
            pending <= '0;
        end else begin
            irq_q   <= irq;
            pending <= (pending & ~clr) | edge_det;
        end
    end

endmodule
`default_nettype wire

// File: rtl/exc_request_ctrl.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module  : exc_request_ctrl                                       |
// | Purpose : Prioritised exception/interrupt requests to datapath.  |
// |           Optional countdown timer enabled by EXC_TIMER_EN.      |
// | Rev     : 1.0  initial release                                   |
// +------------------------------------------------------------------+
module exc_request_ctrl
    import exc_pkg::*;
#(
    parameter int NIRQ    = 4,
    parameter int TIMER_W = 16
) (
    input  wire logic               clk,
    input  wire logic               reset,
    input  wire logic [NIRQ-1:0]    irq,
    input  wire logic               invalid_op,
    input  wire logic               ERet,
    input  wire logic [TIMER_W-1:0] timer_load,
    input  wire logic               timer_we,
    exc_request_ctrl_if.master      bus,
    output logic      [NIRQ-1:0]    pending,
    output logic                    busy,
    output logic                    nested_err
);

    exc_state_t      state, state_n;
    logic [3:0]      estatus, estatus_n;
    logic            ack_fire;
    logic [NIRQ-1:0] irq_clr;
    logic            timer_pending;
    logic [3:0]      irq_code;
    logic [3:0]      req_code;
    logic            req_any;

    assign ack_fire = (state == REQ) && bus.ExcAck;

    // Clear only the source whose code was frozen into EStatus.
    for (genvar i = 0; i < NIRQ; i++) begin : g_clr
        assign irq_clr[i] = ack_fire && (estatus == (EXC_IRQ_BASE + 4'(i)));
    end

    irq_pending_bank #(.NIRQ(NIRQ)) u_bank (
        .clk     (clk),
        .reset   (reset),
        .irq     (irq),
        .clr     (irq_clr),
        .pending (pending)
    );

`ifdef EXC_TIMER_EN
    logic [TIMER_W-1:0] counter;
    logic               timer_set;
    logic               timer_clr;

    assign timer_set = !timer_we && (counter == TIMER_W'(1));
    assign timer_clr = ack_fire && (estatus == EXC_TIMER);

    always_ff @(posedge clk) begin
        if (reset) begin
            counter       <= '0;
            timer_pending <= 1'b0;
        end else begin
            if (timer_we)
                counter <= timer_load;
            else if (counter != '0)
                counter <= counter - 1'b1;

            if (timer_set)
                timer_pending <= 1'b1;
            else if (timer_clr)
                timer_pending <= 1'b0;
        end
    end
`else
    logic unused_timer;
    assign unused_timer  = ^{timer_load, timer_we};
    assign timer_pending = 1'b0;
`endif

    // Lowest IRQ index wins, so scan from the top down.
    always_comb begin
        irq_code = '0;
        for (int i = NIRQ - 1; i >= 0; i--) begin
            if (pending[i])
                irq_code = EXC_IRQ_BASE + 4'(i);
        end
        req_any  = timer_pending || (|pending);
        req_code = timer_pending ? EXC_TIMER : irq_code;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            estatus    <= '0;
            nested_err <= 1'b0;
        end else begin
            state   <= state_n;
            estatus <= estatus_n;
            if ((state == SERVICE) && invalid_op)
                nested_err <= 1'b1;
        end
    end

    always_comb begin
        state_n   = state;
        estatus_n = estatus;
        case (state)
            IDLE: begin
                if (invalid_op) begin
                    state_n   = REQ;
                    estatus_n = EXC_INVOP;
                end else if (req_any) begin
                    state_n   = REQ;
                    estatus_n = req_code;
                end
            end
            REQ: begin
                if (bus.ExcAck)
                    state_n = SERVICE;
            end
            SERVICE: begin
                if (ERet)
                    state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    assign bus.Exc     = (state == REQ);
    assign bus.EStatus = estatus;
    assign busy        = (state == SERVICE);

endmodule
`default_nettype wire

// File: tb/tb_exc_request_ctrl.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module  : tb_exc_request_ctrl                                    |
// | Purpose : Directed bench with request scoreboard for             |
// |           exc_request_ctrl (optionally with EXC_TIMER_EN).       |
// | Rev     : 1.0  initial release                                   |
// +------------------------------------------------------------------+
module tb_exc_request_ctrl;

    localparam int NIRQ    = 4;
    localparam int TIMER_W = 16;

    typedef struct {
        logic [3:0] code;
        int         cyc;
    } exp_t;

    logic               clk = 1'b0;
    logic               reset;
    logic [NIRQ-1:0]    irq;
    logic               invalid_op;
    logic               ERet;
    logic [TIMER_W-1:0] timer_load;
    logic               timer_we;
    logic [NIRQ-1:0]    pending;
    logic               busy;
    logic               nested_err;

    exc_request_ctrl_if bus ();

    exc_request_ctrl #(.NIRQ(NIRQ), .TIMER_W(TIMER_W)) dut (
        .clk        (clk),
        .reset      (reset),
        .irq        (irq),
        .invalid_op (invalid_op),
        .ERet       (ERet),
        .timer_load (timer_load),
        .timer_we   (timer_we),
        .bus        (bus),
        .pending    (pending),
        .busy       (busy),
        .nested_err (nested_err)
    );

    always #5 clk = ~clk;

    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    exp_t expq[$];
    logic exc_prev = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic push(input logic [3:0] code, input int at);
        exp_t e;
        e.code = code;
        e.cyc  = at;
        expq.push_back(e);
    endtask

    // Scoreboard: every new Exc assertion must match the next expected request.
    always @(negedge clk) begin
        if (reset) begin
            exc_prev = 1'b0;
        end else begin
            if (bus.Exc && !exc_prev) begin
                if (expq.size() == 0) begin
                    chk("unexpected_exc", {28'd0, bus.EStatus}, 32'hFFFF_FFFF);
                end else begin
                    exp_t e;
                    e = expq.pop_front();
                    chk("estatus", {28'd0, bus.EStatus}, {28'd0, e.code});
                    chk("exc_cycle", cyc, e.cyc);
                end
            end
            exc_prev = bus.Exc;
        end
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic wait_exc();
        int n = 0;
        while (!bus.Exc && n < 20) begin
            tick();
            n++;
        end
        if (!bus.Exc)
            chk("exc_timeout", 32'd0, 32'd1);
    endtask

    task automatic serve(input bit has_next, input logic [3:0] next_code,
                         input logic [NIRQ-1:0] exp_pend);
        wait_exc();
        bus.ExcAck = 1'b1;
        tick();
        bus.ExcAck = 1'b0;
        chk("exc_low_after_ack", {31'd0, bus.Exc}, 32'd0);
        chk("busy_in_service", {31'd0, busy}, 32'd1);
        chk("pending_after_ack", {28'd0, pending}, {28'd0, exp_pend});
        ERet = 1'b1;
        if (has_next) push(next_code, cyc + 2);
        tick();
        ERet = 1'b0;
        chk("busy_after_eret", {31'd0, busy}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        reset      = 1'b1;
        irq        = '0;
        invalid_op = 1'b0;
        ERet       = 1'b0;
        timer_load = '0;
        timer_we   = 1'b0;
        bus.ExcAck = 1'b0;
        repeat (2) tick();
        chk("rst_exc", {31'd0, bus.Exc}, 32'd0);
        chk("rst_estatus", {28'd0, bus.EStatus}, 32'd0);
        chk("rst_pending", {28'd0, pending}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_nested", {31'd0, nested_err}, 32'd0);
        reset = 1'b0;
        repeat (2) tick();

        // 1: single IRQ, two-cycle latency to Exc
        irq = 4'b0001;
        push(4'h8, cyc + 2);
        tick();
        irq = '0;
        chk("t1_pending", {28'd0, pending}, 32'd1);
        serve(1'b0, 4'h0, 4'b0000);
        repeat (2) tick();

        // 2: two simultaneous IRQs served in priority order
        irq = 4'b0110;
        push(4'h9, cyc + 2);
        tick();
        irq = '0;
        serve(1'b1, 4'hA, 4'b0100);
        serve(1'b0, 4'h0, 4'b0000);
        repeat (2) tick();

        // 3: invalid_op beats an already-pending IRQ
        irq = 4'b0100;
        tick();
        irq = '0;
        invalid_op = 1'b1;
        push(4'h1, cyc + 1);
        tick();
        invalid_op = 1'b0;
        serve(1'b1, 4'hA, 4'b0100);
        serve(1'b0, 4'h0, 4'b0000);
        repeat (2) tick();

        // 4: invalid_op during SERVICE only sets the sticky nested_err
        irq = 4'b0010;
        push(4'h9, cyc + 2);
        tick();
        irq = '0;
        wait_exc();
        bus.ExcAck = 1'b1;
        tick();
        bus.ExcAck = 1'b0;
        invalid_op = 1'b1;
        tick();
        invalid_op = 1'b0;
        chk("t4_nested_set", {31'd0, nested_err}, 32'd1);
        chk("t4_no_exc", {31'd0, bus.Exc}, 32'd0);
        ERet = 1'b1;
        tick();
        ERet = 1'b0;
        repeat (3) tick();
        chk("t4_nested_hold", {31'd0, nested_err}, 32'd1);
        chk("t4_idle", {31'd0, busy}, 32'd0);

        // 5: re-edge on irq[3] coincident with its clear keeps it pending
        irq = 4'b1000;
        push(4'hB, cyc + 2);
        tick();
        irq = '0;
        wait_exc();
        bus.ExcAck = 1'b1;
        irq = 4'b1000;
        tick();
        bus.ExcAck = 1'b0;
        irq = '0;
        chk("t5_pending_kept", {28'd0, pending}, 32'h8);
        chk("t5_busy", {31'd0, busy}, 32'd1);
        ERet = 1'b1;
        push(4'hB, cyc + 2);
        tick();
        ERet = 1'b0;
        serve(1'b0, 4'h0, 4'b0000);
        repeat (2) tick();

        // 6: countdown timer
        timer_load = 16'd5;
        timer_we   = 1'b1;
`ifdef EXC_TIMER_EN
        push(4'h4, cyc + 7);
`endif
        tick();
        timer_we = 1'b0;
`ifdef EXC_TIMER_EN
        serve(1'b0, 4'h0, 4'b0000);
        repeat (10) tick();
        chk("t6_timer_stopped", {31'd0, bus.Exc}, 32'd0);
`else
        repeat (12) tick();
        chk("t6_timer_disabled", {31'd0, bus.Exc}, 32'd0);
`endif

        // Reset mid-operation clears pending and nested_err before any request
        irq = 4'b0001;
        tick();
        irq   = '0;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("rst2_pending", {28'd0, pending}, 32'd0);
        chk("rst2_exc", {31'd0, bus.Exc}, 32'd0);
        chk("rst2_nested", {31'd0, nested_err}, 32'd0);
        repeat (4) tick();
        chk("queue_empty", expq.size(), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
